// File: rtl/wallace_pkg.sv
// Shared constants and elaboration-time helpers for the Wallace multiplier.
package wallace_pkg;

    // Number of registered stages between operand accept and result.
    localparam int MUL_LATENCY = 3;

    // Partial-product rows: one per multiplier bit plus one constant row
    // carrying the Baugh-Wooley correction bits in signed mode.
    function automatic int pp_rows(input int w);
        return w + 1;
    endfunction

    // Rows left after one layer of 3:2 compression of n rows.
    function automatic int csa_next(input int n);
        if (n < 3) begin
            return n;
        end
        return 2 * (n / 3) + (n % 3);
    endfunction

    // Rows left after k layers of 3:2 compression of n rows.
    function automatic int rows_after(input int n, input int k);
        int r;
        r = n;
        for (int i = 0; i < k; i++) begin
            r = csa_next(r);
        end
        return r;
    endfunction

    // Number of 3:2 layers needed to reduce n rows to two.
    function automatic int csa_levels(input int n);
        int r;
        int l;
        r = n;
        l = 0;
        while (r > 2) begin
            r = csa_next(r);
            l++;
        end
        return l;
    endfunction

endpackage

// File: rtl/csa_3to2.sv
// Row-wide 3:2 carry-save compressor: three W-bit rows in, sum and
// left-shifted carry rows out. Bits shifted past W are dropped because the
// whole tree works modulo 2^W.
module csa_3to2 #(
    parameter int W = 32
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    input  logic [W-1:0] z_i,
    output logic [W-1:0] sum_o,
    output logic [W-1:0] carry_o
);

    logic [W-1:0] maj;

    for (genvar gi = 0; gi < W; gi++) begin : g_fa
        assign sum_o[gi] = x_i[gi] ^ y_i[gi] ^ z_i[gi];
        assign maj[gi]   = (x_i[gi] & y_i[gi]) | (x_i[gi] & z_i[gi]) | (y_i[gi] & z_i[gi]);
    end

    assign carry_o = maj << 1;

endmodule

// File: rtl/wallace_mul_pipe.sv
// Pipelined Wallace-tree multiplier, signed/unsigned per operation, with
// valid/ready flow control and a sideband tag.
//   S1: partial products after the first 3:2 layer
//   S2: two-row carry-save result after the remaining layers
//   S3: carry-propagate sum (product)
// The pipe stalls as a whole whenever a result is waiting and not taken.
module wallace_mul_pipe
    import wallace_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int PW = 2 * WIDTH;
    localparam int NR = pp_rows(WIDTH);
    localparam int NL = csa_levels(NR);

    // lvl[k] is the input of 3:2 layer k; lout[k] is its output.
    // Layer 0 feeds the S1 register, so lvl[1] comes from s1_q.
    logic [PW-1:0] pp   [0:NR-1];
    logic [PW-1:0] lvl  [0:NL][0:NR-1];
    logic [PW-1:0] lout [0:NL-1][0:NR-1];

    logic [PW-1:0] s1_d [0:NR-1];
    logic [PW-1:0] s1_q [0:NR-1];
    logic [PW-1:0] s2_d [0:1];
    logic [PW-1:0] s2_q [0:1];
    logic [PW-1:0] sum_d;
    logic [PW-1:0] product_q;

    logic [MUL_LATENCY-1:0] vld_q;
    logic [TAG_W-1:0]       tag_q [0:MUL_LATENCY-1];
    logic                   rdy_q;
    logic                   advance;
    logic                   accept;

    assign advance   = ~vld_q[MUL_LATENCY-1] | out_ready;
    assign in_ready  = advance & rdy_q;
    assign accept    = in_valid & in_ready;
    assign out_valid = vld_q[MUL_LATENCY-1];
    assign product   = product_q;
    assign out_tag   = tag_q[MUL_LATENCY-1];

    // Partial products; in signed mode the MSB row/column cross terms are
    // inverted and 2^W + 2^(2W-1) is added (Baugh-Wooley).
    always_comb begin
        for (int r = 0; r < NR; r++) begin
            pp[r] = '0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                pp[i][i+j] = (a[j] & b[i]) ^ (in_signed & ((i == WIDTH-1) != (j == WIDTH-1)));
            end
        end
        if (in_signed) begin
            pp[WIDTH][WIDTH] = 1'b1;
            pp[WIDTH][PW-1]  = 1'b1;
        end
    end

    // Wire each layer's input rows.
    for (genvar gi = 0; gi < NR; gi++) begin : g_lvl_lo
        assign lvl[0][gi] = pp[gi];
        assign lvl[1][gi] = s1_q[gi];
        assign s1_d[gi]   = lout[0][gi];
    end

    for (genvar gl = 2; gl <= NL; gl++) begin : g_lvl_hi
        for (genvar gi = 0; gi < NR; gi++) begin : g_row
            assign lvl[gl][gi] = lout[gl-1][gi];
        end
    end

    // Compression layers: groups of three rows go through a CSA, leftover
    // rows pass straight through, unused slots are tied to zero.
    for (genvar gl = 0; gl < NL; gl++) begin : g_layer
        localparam int NIN  = rows_after(NR, gl);
        localparam int NGRP = NIN / 3;
        localparam int NOUT = rows_after(NR, gl + 1);

        for (genvar gi = 0; gi < NGRP; gi++) begin : g_csa
            csa_3to2 #(
                .W(PW)
            ) u_csa (
                .x_i     (lvl[gl][3*gi]),
                .y_i     (lvl[gl][3*gi+1]),
                .z_i     (lvl[gl][3*gi+2]),
                .sum_o   (lout[gl][2*gi]),
                .carry_o (lout[gl][2*gi+1])
            );
        end

        for (genvar gi = 0; gi < NIN - 3*NGRP; gi++) begin : g_pass
            assign lout[gl][2*NGRP+gi] = lvl[gl][3*NGRP+gi];
        end

        for (genvar gi = NOUT; gi < NR; gi++) begin : g_zero
            assign lout[gl][gi] = '0;
        end
    end

    assign s2_d[0] = lvl[NL][0];
    assign s2_d[1] = lvl[NL][1];

    // Final carry-propagate add; the carry beyond 2*WIDTH bits is dropped.
    assign sum_d = s2_q[0] + s2_q[1];

    // Input readiness comes up one clock after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    // S1: capture first-layer rows, tag and valid when the pipe advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q[0] <= 1'b0;
            tag_q[0] <= '0;
            for (int r = 0; r < NR; r++) begin
                s1_q[r] <= '0;
            end
        end else if (advance) begin
            vld_q[0] <= accept;
            tag_q[0] <= in_tag;
            for (int r = 0; r < NR; r++) begin
                s1_q[r] <= s1_d[r];
            end
        end
    end

    // S2: capture the two carry-save rows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q[1] <= 1'b0;
            tag_q[1] <= '0;
            s2_q[0]  <= '0;
            s2_q[1]  <= '0;
        end else if (advance) begin
            vld_q[1] <= vld_q[0];
            tag_q[1] <= tag_q[0];
            s2_q[0]  <= s2_d[0];
            s2_q[1]  <= s2_d[1];
        end
    end

    // S3: load product and tag only from a valid op so bubbles never show up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q[2]  <= 1'b0;
            tag_q[2]  <= '0;
            product_q <= '0;
        end else if (advance) begin
            vld_q[2] <= vld_q[1];
            if (vld_q[1]) begin
                tag_q[2]  <= tag_q[1];
                product_q <= sum_d;
            end
        end
    end

endmodule

// File: tb/tb_wallace_mul_pipe.sv
// Scoreboard bench for wallace_mul_pipe (WIDTH=16, TAG_W=4).
module tb_wallace_mul_pipe;

    localparam int W  = 16;
    localparam int TW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    a = '0;
    logic [W-1:0]    b = '0;
    logic            in_signed = 1'b0;
    logic [TW-1:0]   in_tag = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [2*W-1:0]  product;
    logic [TW-1:0]   out_tag;

    typedef struct packed {
        logic [TW-1:0]  tag;
        logic [2*W-1:0] prod;
    } exp_t;

    exp_t           sb [$];
    int             checks = 0;
    int             errors = 0;
    int             n_out  = 0;
    logic           prev_ov = 1'b0;
    logic           prev_or = 1'b0;
    logic [2*W-1:0] prev_prod = '0;
    logic [TW-1:0]  prev_tag = '0;

    wallace_mul_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .in_signed (in_signed),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input bit sg);
        longint sx;
        longint sy;
        longint p;
        if (sg) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end else begin
            sx = longint'(x);
            sy = longint'(y);
        end
        p = sx * sy;
        return p[2*W-1:0];
    endfunction

    // One cycle: drive at the falling edge, then sample handshakes 1ns later.
    task automatic step(input bit v, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input bit sg, input logic [TW-1:0] tg, input bit ordy);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        a         = xa;
        b         = xb;
        in_signed = sg;
        in_tag    = tg;
        out_ready = ordy;
        #1;
        if (prev_ov && !prev_or) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_prod", product, prev_prod);
            chk("hold_tag", out_tag, prev_tag);
        end
        if (out_valid && out_ready) begin
            chk("sb_has_entry", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("product", product, e.prod);
                chk("out_tag", out_tag, e.tag);
                $display("xfer out tag=%0h product=%08h", out_tag, product);
            end
            n_out++;
        end
        if (in_valid && in_ready) begin
            sb.push_back({tg, ref_mul(xa, xb, sg)});
        end
        prev_ov   = out_valid;
        prev_or   = out_ready;
        prev_prod = product;
        prev_tag  = out_tag;
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            4: return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0]   ta [3];
        logic [W-1:0]   tb [3];
        logic [2*W-1:0] te [3];
        int             n0;
        int             acc;
        int             cyc;
        bit             pend;
        bit             v;
        logic [W-1:0]   pa;
        logic [W-1:0]   pb;
        bit             ps;
        logic [TW-1:0]  pt;

        ta = '{16'hFFFF, 16'h8000, 16'h8000};
        tb = '{16'hFFFF, 16'h8000, 16'h0001};
        te = '{32'h00000001, 32'h40000000, 32'hFFFF8000};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_product", product, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("in_ready_before_edge", in_ready, 0);
        step(0, '0, '0, 0, '0, 1);
        chk("in_ready_after_rst", in_ready, 1);

        // Test 1: unsigned max * max, latency check
        step(1, 16'hFFFF, 16'hFFFF, 0, 4'd3, 1);
        for (int k = 1; k <= wallace_pkg::MUL_LATENCY; k++) begin
            step(0, '0, '0, 0, '0, 1);
            if (k < wallace_pkg::MUL_LATENCY) begin
                chk("t1_not_yet", out_valid, 0);
            end else begin
                chk("t1_valid", out_valid, 1);
                chk("t1_product", product, 32'hFFFE0001);
                chk("t1_tag", out_tag, 3);
            end
        end

        // Test 2: signed corner products
        for (int i = 0; i < 3; i++) begin
            step(1, ta[i], tb[i], 1, 4'(i + 8), 1);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, '0, '0, 0, '0, 1);
            chk("t2_valid", out_valid, 1);
            chk("t2_product", product, te[i]);
        end

        // Test 3: 8 back-to-back alternating signed/unsigned
        repeat (3) step(0, '0, '0, 0, '0, 1);
        n0 = n_out;
        for (int i = 0; i < 11; i++) begin
            if (i < 8) begin
                step(1, pick_operand(), pick_operand(), i[0], 4'(i), 1);
            end else begin
                step(0, '0, '0, 0, '0, 1);
            end
            if (i >= 3) begin
                chk("t3_consecutive", out_valid, 1);
            end
        end
        chk("t3_count", n_out - n0, 8);

        // Test 4: back-pressure with a full pipe
        for (int i = 0; i < 3; i++) begin
            step(1, pick_operand(), pick_operand(), i[0], 4'(i + 4), 0);
            chk("t4_fill_accept", in_ready, 1);
        end
        pa = 16'h1234;
        pb = 16'hFEDC;
        for (int i = 0; i < 5; i++) begin
            step(1, pa, pb, 1, 4'hE, 0);
            chk("t4_in_ready_low", in_ready, 0);
        end
        n0 = n_out;
        step(1, pa, pb, 1, 4'hE, 1);
        chk("t4_release_accept", in_ready, 1);
        repeat (6) step(0, '0, '0, 0, '0, 1);
        chk("t4_drain_count", n_out - n0, 4);
        chk("t4_sb_empty", sb.size(), 0);

        // Test 5: reset with two ops in flight
        step(1, 16'h00FF, 16'h0102, 0, 4'h1, 1);
        step(1, 16'h8001, 16'h7FFF, 1, 4'h2, 1);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("t5_rst_out_valid", out_valid, 0);
        chk("t5_rst_product", product, 0);
        chk("t5_rst_in_ready", in_ready, 0);
        sb.delete();
        prev_ov = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(0, '0, '0, 0, '0, 1);
        chk("t5_in_ready_after", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            step(0, '0, '0, 0, '0, 1);
            chk("t5_no_stale", out_valid, 0);
        end

        // Test 6: random traffic against the scoreboard
        acc  = 0;
        cyc  = 0;
        pend = 0;
        pa   = '0;
        pb   = '0;
        ps   = 0;
        pt   = '0;
        while (acc < 10000 && cyc < 60000) begin
            if (!pend) begin
                pa   = pick_operand();
                pb   = pick_operand();
                ps   = 1'($urandom_range(0, 1));
                pt   = 4'($urandom);
                v    = ($urandom_range(0, 3) != 0);
                pend = v;
            end else begin
                v = 1;
            end
            step(v, pa, pb, ps, pt, $urandom_range(0, 3) != 0);
            if (v && in_ready) begin
                acc++;
                pend = 0;
            end
            cyc++;
        end
        chk("t6_accepted", acc, 10000);
        repeat (8) step(0, '0, '0, 0, '0, 1);
        chk("t6_sb_empty", sb.size(), 0);
        chk("t6_idle", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
